// File: rtl/sig_edge_fifo.sv
// Dual timestamped edge queue: rise/fall strobes are logged into an LTR or RTL
// circular queue and popped one entry per cycle with a single-cycle read latency.
module sig_edge_fifo #(
  parameter int DEPTH     = 8,
  parameter int TIME_W    = 32,
  parameter int OVERWRITE = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dir,
  input  logic [TIME_W-1:0]        sig_time,
  input  logic                     sig_rise,
  input  logic                     sig_fall,
  input  logic                     rd_dir,
  input  logic                     rd_en,
  input  logic                     clr_flags,
  output logic                     rd_valid,
  output logic [TIME_W-1:0]        rd_time,
  output logic                     rd_is_rise,
  output logic                     rd_is_ltr,
  output logic [$clog2(DEPTH):0]   count_ltr,
  output logic [$clog2(DEPTH):0]   count_rtl,
  output logic                     empty_ltr,
  output logic                     empty_rtl,
  output logic                     full_ltr,
  output logic                     full_rtl,
  output logic                     ovf_ltr,
  output logic                     ovf_rtl,
  output logic                     glitch_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [TIME_W:0] entry_t;  // {timestamp, is_rise}

  // Index 0 = LTR queue, index 1 = RTL queue.
  entry_t              mem_q [2][DEPTH];
  logic [1:0][PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0][CW-1:0]  cnt_q, cnt_d;
  logic [1:0]          ovf_q, ovf_d;
  logic [1:0]          push, pop, full, we;
  logic                glitch_q, glitch_d;
  logic                rd_valid_q, rd_valid_d;
  logic [TIME_W-1:0]   rd_time_q, rd_time_d;
  logic                rd_is_rise_q, rd_is_rise_d;
  logic                rd_is_ltr_q, rd_is_ltr_d;
  logic                edge_ok;

  assign edge_ok = sig_rise ^ sig_fall;

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    push         = '0;
    pop          = '0;
    full         = '0;
    we           = '0;
    rd_valid_d   = 1'b0;
    rd_time_d    = rd_time_q;
    rd_is_rise_d = rd_is_rise_q;
    rd_is_ltr_d  = rd_is_ltr_q;
    for (int q = 0; q < 2; q++) begin
      push[q] = edge_ok && (dir == 1'(q));
      full[q] = (cnt_q[q] == CW'(DEPTH));
      // Pop is decided on registered occupancy, so a push never bypasses into an empty read.
      pop[q]  = rd_en && (rd_dir == 1'(q)) && (cnt_q[q] != '0);
      we[q]   = push[q] && (pop[q] || !full[q] || (OVERWRITE != 0));
      if (we[q])
        wptr_d[q] = wptr_q[q] + 1'b1;
      if (pop[q] || (push[q] && full[q] && (OVERWRITE != 0)))
        rptr_d[q] = rptr_q[q] + 1'b1;
      if (push[q] && !full[q] && !pop[q])
        cnt_d[q] = cnt_q[q] + 1'b1;
      else if (pop[q] && !push[q])
        cnt_d[q] = cnt_q[q] - 1'b1;
      if (push[q] && full[q] && !pop[q])
        ovf_d[q] = 1'b1;
      else if (clr_flags)
        ovf_d[q] = 1'b0;
      if (pop[q]) begin
        rd_valid_d   = 1'b1;
        rd_time_d    = mem_q[q][rptr_q[q]][TIME_W:1];
        rd_is_rise_d = mem_q[q][rptr_q[q]][0];
        rd_is_ltr_d  = (q == 0);
      end
    end
    if (sig_rise && sig_fall)
      glitch_d = 1'b1;
    else if (clr_flags)
      glitch_d = 1'b0;
    else
      glitch_d = glitch_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      ovf_q        <= '0;
      glitch_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_time_q    <= '0;
      rd_is_rise_q <= 1'b0;
      rd_is_ltr_q  <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      glitch_q     <= glitch_d;
      rd_valid_q   <= rd_valid_d;
      rd_time_q    <= rd_time_d;
      rd_is_rise_q <= rd_is_rise_d;
      rd_is_ltr_q  <= rd_is_ltr_d;
    end
  end

  // Storage is never reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int q = 0; q < 2; q++)
        if (we[q]) mem_q[q][wptr_q[q]] <= {sig_time, sig_rise};
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_time    = rd_time_q;
  assign rd_is_rise = rd_is_rise_q;
  assign rd_is_ltr  = rd_is_ltr_q;
  assign count_ltr  = cnt_q[0];
  assign count_rtl  = cnt_q[1];
  assign empty_ltr  = (cnt_q[0] == '0);
  assign empty_rtl  = (cnt_q[1] == '0);
  assign full_ltr   = full[0];
  assign full_rtl   = full[1];
  assign ovf_ltr    = ovf_q[0];
  assign ovf_rtl    = ovf_q[1];
  assign glitch_err = glitch_q;
endmodule

// File: tb/tb_sig_edge_fifo.sv
// Drives an OVERWRITE=1 and an OVERWRITE=0 instance with identical stimulus and
// checks both against a queue-based scoreboard every cycle.
module tb_sig_edge_fifo;
  localparam int DEPTH = 8;
  localparam int TW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0, reset_n = 1'b0, dir = 1'b0, sig_rise = 1'b0, sig_fall = 1'b0;
  logic rd_dir = 1'b0, rd_en = 1'b0, clr_flags = 1'b0;
  logic [TW-1:0] sig_time = '0;

  logic [1:0] rd_valid, rd_is_rise, rd_is_ltr, empty_ltr, empty_rtl;
  logic [1:0] full_ltr, full_rtl, ovf_ltr, ovf_rtl, glitch_err;
  logic [1:0][TW-1:0] rd_time;
  logic [1:0][CW-1:0] count_ltr, count_rtl;

  always #5 clk = ~clk;

  // Instance 0 overwrites oldest on overflow, instance 1 drops the new entry.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    sig_edge_fifo #(.DEPTH(DEPTH), .TIME_W(TW), .OVERWRITE((g == 0) ? 1 : 0)) u_dut (
      .clk(clk), .reset_n(reset_n), .dir(dir), .sig_time(sig_time),
      .sig_rise(sig_rise), .sig_fall(sig_fall), .rd_dir(rd_dir), .rd_en(rd_en),
      .clr_flags(clr_flags), .rd_valid(rd_valid[g]), .rd_time(rd_time[g]),
      .rd_is_rise(rd_is_rise[g]), .rd_is_ltr(rd_is_ltr[g]),
      .count_ltr(count_ltr[g]), .count_rtl(count_rtl[g]),
      .empty_ltr(empty_ltr[g]), .empty_rtl(empty_rtl[g]),
      .full_ltr(full_ltr[g]), .full_rtl(full_rtl[g]),
      .ovf_ltr(ovf_ltr[g]), .ovf_rtl(ovf_rtl[g]), .glitch_err(glitch_err[g]));
  end

  // Scoreboard: queue index = 2*dut + dir; entries are {time, is_rise}.
  logic [TW:0]        mq [4][$];
  logic [1:0][1:0]    m_ovf;
  logic               m_glitch;
  logic [1:0]         m_valid, m_rise, m_ltr;
  logic [1:0][TW-1:0] m_time;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk("rd_valid",   k, 64'(rd_valid[k]),   64'(m_valid[k]));
      chk("rd_time",    k, 64'(rd_time[k]),    64'(m_time[k]));
      chk("rd_is_rise", k, 64'(rd_is_rise[k]), 64'(m_rise[k]));
      chk("rd_is_ltr",  k, 64'(rd_is_ltr[k]),  64'(m_ltr[k]));
      chk("count_ltr",  k, 64'(count_ltr[k]),  64'(mq[2*k].size()));
      chk("count_rtl",  k, 64'(count_rtl[k]),  64'(mq[2*k+1].size()));
      chk("empty_ltr",  k, 64'(empty_ltr[k]),  64'(mq[2*k].size() == 0));
      chk("empty_rtl",  k, 64'(empty_rtl[k]),  64'(mq[2*k+1].size() == 0));
      chk("full_ltr",   k, 64'(full_ltr[k]),   64'(mq[2*k].size() == DEPTH));
      chk("full_rtl",   k, 64'(full_rtl[k]),   64'(mq[2*k+1].size() == DEPTH));
      chk("ovf_ltr",    k, 64'(ovf_ltr[k]),    64'(m_ovf[k][0]));
      chk("ovf_rtl",    k, 64'(ovf_rtl[k]),    64'(m_ovf[k][1]));
      chk("glitch_err", k, 64'(glitch_err[k]), 64'(m_glitch));
    end
  endtask

  task automatic idle_inputs();
    dir = 0; sig_rise = 0; sig_fall = 0; sig_time = '0; rd_en = 0; rd_dir = 0; clr_flags = 0;
  endtask

  task automatic step(input bit pe, input bit d, input bit r, input bit f, input logic [TW-1:0] t,
                      input bit re, input bit rdd, input bit clr);
    logic [TW:0] e;
    logic [1:0] set;
    dir = d; sig_rise = pe & r; sig_fall = pe & f; sig_time = t;
    rd_en = re; rd_dir = rdd; clr_flags = clr;
    for (int k = 0; k < 2; k++) begin
      set = '0;
      m_valid[k] = 1'b0;
      if (re && mq[2*k+rdd].size() != 0) begin
        e = mq[2*k+rdd].pop_front();
        m_valid[k] = 1'b1; m_time[k] = e[TW:1]; m_rise[k] = e[0]; m_ltr[k] = ~rdd;
      end
      if (sig_rise ^ sig_fall) begin
        if (mq[2*k+d].size() == DEPTH) begin
          set[d] = 1'b1;
          if (k == 0) begin
            e = mq[2*k+d].pop_front();
            mq[2*k+d].push_back({t, sig_rise});
          end
        end else begin
          mq[2*k+d].push_back({t, sig_rise});
        end
      end
      for (int dd = 0; dd < 2; dd++)
        m_ovf[k][dd] = set[dd] ? 1'b1 : (clr ? 1'b0 : m_ovf[k][dd]);
    end
    m_glitch = (sig_rise && sig_fall) ? 1'b1 : (clr ? 1'b0 : m_glitch);
    @(posedge clk); #1;
    idle_inputs();
    check_all();
  endtask

  task automatic push(input bit d, input logic [TW-1:0] t, input bit rise);
    step(1, d, rise, !rise, t, 0, 0, 0);
  endtask

  task automatic pop(input bit d);
    step(0, 0, 0, 0, '0, 1, d, 0);
  endtask

  // Reset with optional live traffic on the inputs, which must be ignored.
  task automatic do_reset(input bit busy);
    reset_n = 1'b0;
    if (busy) begin
      dir = 0; sig_rise = 1; sig_time = 32'd777; rd_en = 1; rd_dir = 0; clr_flags = 1;
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_ovf = '0; m_glitch = 0; m_valid = '0; m_time = '0; m_rise = '0; m_ltr = '0;
    check_all();
  endtask

  initial begin
    idle_inputs();
    do_reset(0);

    // Basic ordering across both queues, plus an independent cross-queue push/pop.
    push(0, 32'd100, 1);
    push(0, 32'd200, 0);
    push(1, 32'd150, 1);
    pop(0);
    step(1, 1, 0, 1, 32'd160, 1, 0, 0);
    pop(1);
    pop(1);
    step(0, 0, 0, 0, '0, 0, 0, 0);

    // Overflow: 10 pushes into an 8-deep LTR queue, then drain past empty.
    for (int i = 1; i <= 10; i++) push(0, TW'(i), i[0]);
    for (int i = 0; i < 9; i++) pop(0);
    step(0, 0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, 0, '0, 0, 0, 1);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) push(0, TW'(20 + i), 1);
    step(1, 0, 0, 1, 32'd99, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) pop(0);

    // Empty RTL queue: same-cycle push and pop must not bypass.
    step(1, 1, 1, 0, 32'd5, 1, 1, 0);
    pop(1);
    pop(1);

    // Glitch strobes, clear collision, then clear.
    push(0, 32'd40, 1);
    step(1, 0, 1, 1, 32'd41, 0, 0, 0);
    step(1, 1, 1, 1, 32'd42, 0, 0, 1);
    step(0, 0, 0, 0, '0, 0, 0, 1);

    // Reset with entries queued and traffic on the inputs.
    push(0, 32'd50, 1);
    push(1, 32'd51, 0);
    push(1, 32'd52, 1);
    do_reset(1);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 1'b1 : 1'($urandom_range(0, 1)) & 1'($urandom_range(0, 1)),
           TW'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
